voice_allocator: RTL and testbench

Assigns incoming note-on/note-off events to the `N_OSCILLATORS` wavegenerator voices and tracks each voice's lifecycle (free, held, releasing). Produces the per-voice enable, note, velocity, gate and trigger controls that drive the wavegenerator/envelope bank. Produces the registered `num_enabled` count consumed by the mixer's loudness normalisation. When all voices are busy, it steals voices by a fixed priority and age policy.

---
 rtl/voice_allocator_if.sv | 27 ++
 rtl/voice_allocator.sv | 181 ++++++++++++++++++
 tb/tb_voice_allocator.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/voice_allocator_if.sv
// voice_allocator_if: note-on handshake and note-off strobe between the
// event source (master) and the voice allocator (slave).
//   note_on_valid/ready : note-on handshake, accepted on valid && ready
//   note_on_note/vel    : note number and velocity of the note-on
//   note_off_valid      : note-off strobe, always accepted
//   note_off_note       : note number of the note-off
interface voice_allocator_if #(
  parameter int NOTE_W = 7,
  parameter int VEL_W  = 7
);
  logic              note_on_valid;
  logic              note_on_ready;
  logic [NOTE_W-1:0] note_on_note;
  logic [VEL_W-1:0]  note_on_vel;
  logic              note_off_valid;
  logic [NOTE_W-1:0] note_off_note;

  modport master (
    output note_on_valid, note_on_note, note_on_vel, note_off_valid, note_off_note,
    input  note_on_ready
  );

  modport slave (
    input  note_on_valid, note_on_note, note_on_vel, note_off_valid, note_off_note,
    output note_on_ready
  );
endinterface

// File: rtl/voice_allocator.sv
// voice_allocator: assigns note-on events to voices and tracks each voice
// through FREE -> ACTIVE -> RELEASING -> FREE. A note-on is scanned over all
// voices one per cycle, then committed in a single ASSIGN cycle. When no voice
// is free it steals: retrigger same note > free > oldest releasing > oldest active.
// Ports:
//   clk, rst          : clock, async active-high reset
//   bus (slave)       : note-on handshake and note-off strobe
//   release_done      : per-voice envelope release finished
//   voice_enable      : voice not FREE
//   voice_gate        : voice ACTIVE (key held)
//   voice_trigger     : one-cycle pulse on (re)assignment
//   voice_note/vel    : per-voice assigned note and velocity
//   num_enabled       : registered count of non-FREE voices
`ifndef N_OSCILLATORS
`define N_OSCILLATORS 4
`endif

module voice_allocator #(
  parameter int N_VOICES = `N_OSCILLATORS,
  parameter int NOTE_W   = 7,
  parameter int VEL_W    = 7,
  parameter int AGE_W    = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  voice_allocator_if.slave                 bus,
  input  logic [N_VOICES-1:0]              release_done,
  output logic [N_VOICES-1:0]              voice_enable,
  output logic [N_VOICES-1:0]              voice_gate,
  output logic [N_VOICES-1:0]              voice_trigger,
  output logic [N_VOICES-1:0][NOTE_W-1:0]  voice_note,
  output logic [N_VOICES-1:0][VEL_W-1:0]   voice_vel,
  output logic signed [31:0]               num_enabled
);
  localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef enum logic [1:0] {V_FREE, V_ACTIVE, V_REL} vst_e;
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_ASSIGN} fsm_e;

  fsm_e                         fsm_q, fsm_d;
  logic [IDX_W-1:0]             scan_q, scan_d, cand_q, cand_d;
  logic [1:0]                   crank_q, crank_d;
  logic [AGE_W-1:0]             cage_q, cage_d;
  logic [NOTE_W-1:0]            req_note_q;
  logic [VEL_W-1:0]             req_vel_q;
  logic signed [31:0]           num_q;

  vst_e                         st [N_VOICES];
  logic [N_VOICES-1:0][AGE_W-1:0] age;

  logic accept;
  vst_e scan_st;
  logic [1:0] rank;
  logic better;

  // Ready is gated by rst so it reads 0 for the whole reset assertion.
  assign bus.note_on_ready = (fsm_q == S_IDLE) && !rst;
  assign accept            = bus.note_on_valid && bus.note_on_ready;
  assign num_enabled       = num_q;

  // Rank of the voice examined this scan cycle: 3 same note, 2 free,
  // 1 releasing, 0 active. Age only breaks ties in the two steal classes;
  // strict compares keep the lowest index on equal terms.
  assign scan_st = st[scan_q];
  always_comb begin
    rank = 2'd0;
    if (scan_st != V_FREE && voice_note[scan_q] == req_note_q) rank = 2'd3;
    else if (scan_st == V_FREE)                                rank = 2'd2;
    else if (scan_st == V_REL)                                 rank = 2'd1;
    better = (scan_q == '0) || (rank > crank_q) ||
             (rank == crank_q && !rank[1] && age[scan_q] > cage_q);
  end

  always_comb begin
    fsm_d   = fsm_q;
    scan_d  = scan_q;
    cand_d  = cand_q;
    crank_d = crank_q;
    cage_d  = cage_q;
    case (fsm_q)
      S_IDLE: if (accept) begin
        fsm_d  = S_SCAN;
        scan_d = '0;
      end
      S_SCAN: begin
        if (better) begin
          cand_d  = scan_q;
          crank_d = rank;
          cage_d  = age[scan_q];
        end
        if (scan_q == IDX_W'(N_VOICES-1)) fsm_d = S_ASSIGN;
        else                              scan_d = scan_q + IDX_W'(1);
      end
      S_ASSIGN: fsm_d = S_IDLE;
      default:  fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= S_IDLE;
      scan_q     <= '0;
      cand_q     <= '0;
      crank_q    <= '0;
      cage_q     <= '0;
      req_note_q <= '0;
      req_vel_q  <= '0;
      num_q      <= '0;
    end else begin
      fsm_q   <= fsm_d;
      scan_q  <= scan_d;
      cand_q  <= cand_d;
      crank_q <= crank_d;
      cage_q  <= cage_d;
      num_q   <= $countones(voice_enable);
      if (accept) begin
        req_note_q <= bus.note_on_note;
        req_vel_q  <= bus.note_on_vel;
      end
    end
  end

  for (genvar i = 0; i < N_VOICES; i++) begin : g_voice
    vst_e              st_q, st_d;
    logic [AGE_W-1:0]  age_q, age_d;
    logic [NOTE_W-1:0] note_q, note_d;
    logic [VEL_W-1:0]  vel_q, vel_d;
    logic              trig_q, hit;

    assign hit = (fsm_q == S_ASSIGN) && (cand_q == IDX_W'(i));

    // The assignment overrides any note-off or release_done landing on the
    // candidate in the same cycle.
    always_comb begin
      st_d   = st_q;
      age_d  = age_q;
      note_d = note_q;
      vel_d  = vel_q;
      if (hit) begin
        st_d   = V_ACTIVE;
        age_d  = '0;
        note_d = req_note_q;
        vel_d  = req_vel_q;
      end else begin
        if (fsm_q == S_ASSIGN && st_q != V_FREE && age_q != AGE_MAX)
          age_d = age_q + 1'b1;
        if (bus.note_off_valid && st_q == V_ACTIVE && note_q == bus.note_off_note)
          st_d = V_REL;
        else if (release_done[i] && st_q == V_REL) begin
          st_d  = V_FREE;
          age_d = '0;
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st_q   <= V_FREE;
        age_q  <= '0;
        note_q <= '0;
        vel_q  <= '0;
        trig_q <= 1'b0;
      end else begin
        st_q   <= st_d;
        age_q  <= age_d;
        note_q <= note_d;
        vel_q  <= vel_d;
        trig_q <= hit;
      end
    end

    assign st[i]            = st_q;
    assign age[i]           = age_q;
    assign voice_enable[i]  = (st_q != V_FREE);
    assign voice_gate[i]    = (st_q == V_ACTIVE);
    assign voice_trigger[i] = trig_q;
    assign voice_note[i]    = note_q;
    assign voice_vel[i]     = vel_q;
  end
endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: table of note-on/off/release_done operations with the
// expected enable/gate/count after each, plus hand sequences for reset, the
// release_done-vs-ASSIGN collision and reset mid-scan. Every note-on pushes
// its expected voice/note/vel; a negedge monitor pops on each trigger.
module tb_voice_allocator;
  localparam int N  = 4;
  localparam int NW = 7;
  localparam int VW = 7;
  localparam int ON = 0, OFF = 1, RD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  voice_allocator_if #(.NOTE_W(NW), .VEL_W(VW)) bus ();
  logic [N-1:0]         release_done;
  logic [N-1:0]         voice_enable, voice_gate, voice_trigger;
  logic [N-1:0][NW-1:0] voice_note;
  logic [N-1:0][VW-1:0] voice_vel;
  logic signed [31:0]   num_enabled;

  voice_allocator #(.N_VOICES(N), .NOTE_W(NW), .VEL_W(VW), .AGE_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus), .release_done(release_done),
    .voice_enable(voice_enable), .voice_gate(voice_gate), .voice_trigger(voice_trigger),
    .voice_note(voice_note), .voice_vel(voice_vel), .num_enabled(num_enabled)
  );

  int checks = 0;
  int failures = 0;

  typedef struct { int v; int note; int vel; } exp_t;
  exp_t sb[$];
  exp_t e;

  typedef struct {
    int op; int note; int vel; int arg;
    logic [N-1:0] en; logic [N-1:0] gate; int num;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard side: every trigger must match the oldest pending note-on.
  always @(negedge clk) begin
    if (voice_trigger !== '0) begin
      if (sb.size() == 0) chk("unexpected_trigger", 32'(voice_trigger), 0);
      else begin
        e = sb.pop_front();
        chk("trig_onehot", 32'($onehot(voice_trigger)), 1);
        chk("trig_voice",  32'(voice_trigger), 32'(1 << e.v));
        chk("trig_note",   32'(voice_note[e.v]), e.note);
        chk("trig_vel",    32'(voice_vel[e.v]), e.vel);
        chk("trig_gate",   32'(voice_gate[e.v]), 1);
      end
    end
  end

  // Drives one note-on, checks its N+1 latency; rd is pulsed in the ASSIGN cycle.
  task automatic note_on(input int note, input int vel, input int v, input logic [N-1:0] rd);
    int n;
    @(negedge clk);
    n = 0;
    while (!bus.note_on_ready && n < 50) begin @(negedge clk); n++; end
    chk("ready_before_on", 32'(bus.note_on_ready), 1);
    bus.note_on_valid = 1'b1;
    bus.note_on_note  = NW'(note);
    bus.note_on_vel   = VW'(vel);
    sb.push_back('{v, note, vel});
    @(negedge clk);
    bus.note_on_valid = 1'b0;
    chk("busy_after_accept", 32'(bus.note_on_ready), 0);
    repeat (N) @(negedge clk);
    chk("no_early_trigger", 32'(voice_trigger), 0);
    release_done = rd;
    @(negedge clk);
    release_done = '0;
    chk("trigger_latency", 32'(voice_trigger[v]), 1);
    chk("ready_after_assign", 32'(bus.note_on_ready), 1);
  endtask

  task automatic note_off(input int note);
    @(negedge clk);
    bus.note_off_valid = 1'b1;
    bus.note_off_note  = NW'(note);
    @(negedge clk);
    bus.note_off_valid = 1'b0;
  endtask

  task automatic rdone(input logic [N-1:0] m);
    @(negedge clk);
    release_done = m;
    @(negedge clk);
    release_done = '0;
  endtask

  task automatic chk_state(input string tag, input logic [N-1:0] en, input logic [N-1:0] g, input int num);
    chk({tag, "_enable"}, 32'(voice_enable), 32'(en));
    chk({tag, "_gate"},   32'(voice_gate), 32'(g));
    chk({tag, "_num"},    num_enabled, num);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // notes per voice after the table: v0=72 v1=70 v2=62 v3=71
    tbl.push_back('{ON,  60, 100, 0, 4'b0001, 4'b0001, 1});
    tbl.push_back('{OFF, 60,   0, 0, 4'b0001, 4'b0000, 1});
    tbl.push_back('{RD,   0,   0, 1, 4'b0000, 4'b0000, 0});
    tbl.push_back('{ON,  60, 100, 0, 4'b0001, 4'b0001, 1});
    tbl.push_back('{OFF, 60,   0, 0, 4'b0001, 4'b0000, 1});
    tbl.push_back('{ON,  60,  40, 0, 4'b0001, 4'b0001, 1});   // retrigger releasing v0
    tbl.push_back('{ON,  61,  10, 1, 4'b0011, 4'b0011, 2});
    tbl.push_back('{ON,  62,  20, 2, 4'b0111, 4'b0111, 3});
    tbl.push_back('{ON,  63,  30, 3, 4'b1111, 4'b1111, 4});
    tbl.push_back('{ON,  64,  50, 0, 4'b1111, 4'b1111, 4});   // steal oldest
    tbl.push_back('{ON,  65,  55, 1, 4'b1111, 4'b1111, 4});
    tbl.push_back('{OFF, 65,   0, 0, 4'b1111, 4'b1101, 4});
    tbl.push_back('{ON,  70,  70, 1, 4'b1111, 4'b1111, 4});   // releasing beats older active v2
    tbl.push_back('{OFF, 64,   0, 0, 4'b1111, 4'b1110, 4});
    tbl.push_back('{OFF, 63,   0, 0, 4'b1111, 4'b0110, 4});
    tbl.push_back('{ON,  71,  71, 3, 4'b1111, 4'b1110, 4});   // oldest releasing (v3 age3 > v0 age2)
    tbl.push_back('{OFF, 99,   0, 0, 4'b1111, 4'b1110, 4});   // no match
    tbl.push_back('{RD,   0,   0, 6, 4'b1111, 4'b1110, 4});   // ignored on active voices
    tbl.push_back('{RD,   0,   0, 1, 4'b1110, 4'b1110, 3});
    tbl.push_back('{ON,  72,  72, 0, 4'b1111, 4'b1111, 4});   // free beats everything but retrigger
    tbl.push_back('{ON,  70,   5, 1, 4'b1111, 4'b1111, 4});   // retrigger active v1

    rst = 1'b1;
    release_done = '0;
    bus.note_on_valid = 1'b0; bus.note_on_note = '0; bus.note_on_vel = '0;
    bus.note_off_valid = 1'b0; bus.note_off_note = '0;
    repeat (2) @(negedge clk);
    chk_state("reset", '0, '0, 0);
    chk("reset_trigger", 32'(voice_trigger), 0);
    chk("reset_note", 32'(voice_note), 0);
    chk("reset_vel", 32'(voice_vel), 0);
    chk("reset_ready", 32'(bus.note_on_ready), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(bus.note_on_ready), 1);

    foreach (tbl[k]) begin
      case (tbl[k].op)
        ON:      note_on(tbl[k].note, tbl[k].vel, tbl[k].arg, '0);
        OFF:     note_off(tbl[k].note);
        default: rdone(tbl[k].arg[N-1:0]);
      endcase
      repeat (2) @(negedge clk);
      chk_state($sformatf("vec%0d", k), tbl[k].en, tbl[k].gate, tbl[k].num);
    end

    // release_done on the chosen (releasing) voice during its ASSIGN cycle
    note_off(62);
    @(negedge clk);
    chk("off62_gate", 32'(voice_gate), 32'(4'b1011));
    note_on(80, 80, 2, 4'b0100);
    repeat (2) @(negedge clk);
    chk_state("collide", 4'b1111, 4'b1111, 4);
    chk("collide_note", 32'(voice_note[2]), 80);

    // reset in the middle of a scan aborts the allocation
    @(negedge clk);
    bus.note_on_valid = 1'b1; bus.note_on_note = 7'd90; bus.note_on_vel = 7'd9;
    @(negedge clk);
    bus.note_on_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_state("midscan_rst", '0, '0, 0);
    chk("midscan_rst_trigger", 32'(voice_trigger), 0);
    chk("midscan_rst_ready", 32'(bus.note_on_ready), 0);
    repeat (N + 2) @(negedge clk);
    rst = 1'b0;
    repeat (N + 3) @(negedge clk);
    chk_state("after_abort", '0, '0, 0);
    note_on(61, 3, 0, '0);
    repeat (2) @(negedge clk);
    chk_state("post_reset_on", 4'b0001, 4'b0001, 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
